// File: rtl/comparison_scheduler.sv
// Arbitrates two requesters onto one registered comparison unit and returns the 1-bit outcome.
// Define CMP_SCHED_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module comparison_scheduler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [SEL_WIDTH-1:0]  req0_select,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [SEL_WIDTH-1:0]  req1_select,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic                  rsp_result,
  output logic                  rsp_err,
  output logic [SEL_WIDTH-1:0]  cmp_select,
  output logic [DATA_WIDTH-1:0] cmp_a,
  output logic [DATA_WIDTH-1:0] cmp_b,
  input  logic                  cmp_result,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EVAL, CAPT, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_idle;
  logic                  w_grant1;
  logic                  w_accept;
  logic                  w_rsp_take;
  logic [SEL_WIDTH-1:0]  w_sel;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic                  r_owner;
  logic                  r_illegal;

`ifdef CMP_SCHED_RR_EN
  // r_last holds the most recently granted port; reset value 1 lets port 0 win the first tie.
  logic r_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant1;
    end
  end

  assign w_grant1 = req1_valid & (~req0_valid | ~r_last);
`else
  assign w_grant1 = req1_valid & ~req0_valid;
`endif

  assign w_idle     = (r_state == IDLE);
  assign req0_ready = w_idle & req0_valid & ~w_grant1;
  assign req1_ready = w_idle & w_grant1;
  assign w_accept   = req0_ready | req1_ready;
  assign busy       = ~w_idle;
  assign w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;

  assign w_sel = w_grant1 ? req1_select : req0_select;
  assign w_a   = w_grant1 ? req1_a      : req0_a;
  assign w_b   = w_grant1 ? req1_b      : req0_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EVAL;
      EVAL:    w_next = CAPT;
      CAPT:    w_next = RESP;
      RESP:    if (w_rsp_take) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp_select <= '0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      r_owner    <= 1'b0;
      r_illegal  <= 1'b0;
      rsp_result <= 1'b0;
      rsp_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        cmp_select <= w_sel;
        cmp_a      <= w_a;
        cmp_b      <= w_b;
        r_owner    <= w_grant1;
        r_illegal  <= (w_sel >= SEL_WIDTH'(10));
      end
      if (r_state == CAPT) begin
        rsp_result <= cmp_result & ~r_illegal;
        rsp_err    <= r_illegal;
        rsp0_valid <= ~r_owner;
        rsp1_valid <= r_owner;
      end
      if ((r_state == RESP) && w_rsp_take) begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_comparison_scheduler.sv
// Scoreboard bench for comparison_scheduler with an external registered comparison-unit model.
module tb_comparison_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_select, req1_select;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic        rsp_result, rsp_err;
  logic [3:0]  cmp_select;
  logic [31:0] cmp_a, cmp_b;
  logic        cmp_result;
  logic        busy;

  comparison_scheduler #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_select(req0_select),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_select(req1_select),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .cmp_select(cmp_select), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_result(cmp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   port;
    logic res;
    logic err;
    int   acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   hold_cnt = 0;
  int   last_grant = 1;
  bit   active = 1'b0;
  logic cmp_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Comparison unit: registers its answer one edge after its inputs; junk (1) for illegal codes.
  function automatic logic unit_eval(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'd0: return a == b;
      4'd1: return a != b;
      4'd2: return $signed(a) <  $signed(b);
      4'd3: return a <  b;
      4'd4: return $signed(a) <= $signed(b);
      4'd5: return a <= b;
      4'd6: return $signed(a) >  $signed(b);
      4'd7: return a >  b;
      4'd8: return $signed(a) >= $signed(b);
      4'd9: return a >= b;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) cmp_q <= 1'b0;
    else        cmp_q <= unit_eval(cmp_select, cmp_a, cmp_b);
  end
  assign cmp_result = cmp_q;

  // Reference: signed order obtained by flipping the sign bit and comparing unsigned.
  task automatic ref_eval(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                          output logic res, output logic err);
    logic [31:0] sa, sb;
    sa  = a ^ 32'h8000_0000;
    sb  = b ^ 32'h8000_0000;
    err = (s > 4'd9);
    case (s)
      4'd0: res = (a == b);
      4'd1: res = (a != b);
      4'd2: res = (sa < sb);
      4'd3: res = (a < b);
      4'd4: res = !(sb < sa);
      4'd5: res = !(b < a);
      4'd6: res = (sb < sa);
      4'd7: res = (b < a);
      4'd8: res = !(sa < sb);
      4'd9: res = !(a < b);
      default: res = 1'b0;
    endcase
  endtask

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input int port, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    int   n;
    logic got, r, e;
    exp_t x;
    n = 0;
    if (port == 0) begin
      req0_valid = 1'b1; req0_select = sel; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_select = sel; req1_a = a; req1_b = b;
    end
    forever begin
      @(negedge clk);
      got = (port == 0) ? req0_ready : req1_ready;
      if (got) break;
      n++;
      if (n > 300) begin
        check_eq("accept_timeout", 64'(port), 64'hFF);
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        return;
      end
    end
    ref_eval(sel, a, b, r, e);
    x.port = port; x.res = r; x.err = e; x.acc = cyc + 1;
    exp_q.push_back(x);
    @(posedge clk);
    last_grant = port;
    #1;
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || active || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(n < 500), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Consumer: random response-ready, forced low for hold_cnt cycles of a presented response.
  initial begin
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        if (rsp0_valid || rsp1_valid) hold_cnt--;
      end else begin
        rsp0_ready = ($urandom_range(0, 3) != 0);
        rsp1_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: arbitration rules, response ordering, latency, and stability while held.
  initial begin
    logic exp1;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (!busy && req0_valid && req1_valid) begin
`ifdef CMP_SCHED_RR_EN
          exp1 = (last_grant == 0);
`else
          exp1 = 1'b0;
`endif
          check_eq("tie_grant", {62'd0, req1_ready, req0_ready}, {62'd0, exp1, !exp1});
        end
        if (busy && (req0_ready || req1_ready))
          check_eq("ready_while_busy", {62'd0, req1_ready, req0_ready}, 64'd0);
        if (rsp0_valid || rsp1_valid) begin
          check_eq("one_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, rsp1_valid ? 64'd2 : 64'd1);
          check_eq("busy_in_resp", 64'(busy), 64'd1);
          if (!active) begin
            if (exp_q.size() == 0) begin
              check_eq("unexpected_rsp", 64'(cyc), 64'hDEAD);
            end else begin
              cur = exp_q.pop_front();
              active = 1'b1;
              check_eq("rsp_port", 64'(rsp1_valid), 64'(cur.port));
              check_eq("latency", 64'(cyc), 64'(cur.acc + 2));
            end
          end
          if (active) begin
            check_eq("rsp_result", 64'(rsp_result), 64'(cur.res));
            check_eq("rsp_err", 64'(rsp_err), 64'(cur.err));
          end
          if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) active = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req0_select = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_select = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    check_eq("rst_rsp_result", 64'(rsp_result), 64'd0);
    check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
    check_eq("rst_cmp_select", 64'(cmp_select), 64'd0);
    check_eq("rst_cmp_a", 64'(cmp_a), 64'd0);
    check_eq("rst_cmp_b", 64'(cmp_b), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    send(0, 4'd0, 32'h8, 32'h8);
    send(0, 4'd0, 32'h8, 32'h7);
    wait_idle();
    send(1, 4'd2, 32'h8000_0009, 32'h7);
    send(1, 4'd3, 32'h8000_0009, 32'h7);
    wait_idle();

    fork
      send(1, 4'd7, 32'h8000_0003, 32'h7);
      begin
        repeat (3) send(0, 4'd8, 32'h7, 32'h7);
      end
    join
    wait_idle();

    send(0, 4'd12, 32'h1, 32'h2);
    wait_idle();

    hold_cnt = 5;
    fork
      send(0, 4'd5, 32'h3, 32'h3);
      begin
        for (int n = 0; n < 50 && !busy; n++) @(negedge clk);
        send(1, 4'd9, 32'h1, 32'h2);
      end
    join
    wait_idle();

    fork
      for (int i = 0; i < 25; i++) begin
        logic [31:0] a;
        a = $urandom;
        send(0, 4'($urandom_range(0, 15)), a, ($urandom_range(0, 2) == 0) ? a : $urandom);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int j = 0; j < 25; j++) begin
        logic [31:0] a;
        a = $urandom;
        send(1, 4'($urandom_range(0, 15)), a, ($urandom_range(0, 2) == 0) ? a : $urandom);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    join
    wait_idle();

    // Mid-flight reset: accept a request, then pull reset during EVAL.
    req0_valid = 1'b1; req0_select = 4'd0; req0_a = 32'h5; req0_b = 32'h5;
    for (int n = 0; n < 50 && !req0_ready; n++) @(negedge clk);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("busy_in_eval", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    check_eq("midrst_cmp_a", 64'(cmp_a), 64'd0);
    last_grant = 1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(0, 4'd6, 32'h9, 32'h2);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
